// File: rtl/apb4_mem_slave.sv
// APB4 word-addressed memory slave with configurable wait states,
// a read-only upper region and a privileged-only word 0.
module apb4_mem_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0,
  parameter int RO_BASE     = MEM_DEPTH
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [2:0]              PPROT,
  output logic                    PREADY,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PSLVERR
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int MIW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_next;
  logic                  r_err;
  logic                  r_wr;
  logic [MIW-1:0]        r_idx;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_off_nz;
  logic                  w_err;
  logic                  w_setup;
  logic                  w_wr_en;
  logic                  w_unused;

  // Address decode and error classification, evaluated during setup phase
  assign w_idx    = PADDR >> OFFW;
  assign w_off_nz = |(PADDR & ADDR_WIDTH'(NB - 1));
  assign w_err    = (w_idx >= ADDR_WIDTH'(MEM_DEPTH))
                 || w_off_nz
                 || (PWRITE && (w_idx >= ADDR_WIDTH'(RO_BASE)))
                 || (PWRITE && !PPROT[0] && (w_idx == '0));
  assign w_setup  = (r_state == IDLE) && PSEL && !PENABLE;
  assign w_wr_en  = PREADY && r_wr && !r_err;
  assign w_unused = &{1'b0, PPROT[2:1]};

  // State and wait counter register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next state, counter and handshake outputs; address never feeds this path
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    PREADY     = 1'b0;
    PSLVERR    = 1'b0;
    case (r_state)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          w_next     = ACCESS;
          w_cnt_next = 4'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          w_next = IDLE;
        end else if (PENABLE) begin
          if (r_cnt != '0) begin
            w_cnt_next = r_cnt - 4'd1;
          end else begin
            PREADY  = 1'b1;
            PSLVERR = r_err;
            w_next  = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Latch transfer attributes and read data on the setup-to-access edge
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_err  <= 1'b0;
      r_wr   <= 1'b0;
      r_idx  <= '0;
      PRDATA <= '0;
    end else if (w_setup) begin
      r_err <= w_err;
      r_wr  <= PWRITE;
      r_idx <= w_idx[MIW-1:0];
      if (!PWRITE) begin
        PRDATA <= w_err ? '0 : r_mem[w_idx[MIW-1:0]];
      end
    end
  end

  // Byte-lane memory write in the completing access cycle; storage is not reset
  always_ff @(posedge PCLK) begin
    if (w_wr_en) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (PSTRB[b]) begin
          r_mem[r_idx][b*8 +: 8] <= PWDATA[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Scoreboard bench: DUT A (no wait states, read-only from word 512) and
// DUT B (three wait states, fully writable) share the APB bus signals.
module tb_apb4_mem_slave;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [31:0] PADDR;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic        pselA, pselB;
  logic        readyA, readyB, errA, errB;
  logic [31:0] rdataA, rdataB;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    bit          wr;
    bit          err;
    bit          chk_data;
    logic [31:0] rdata;
    int          waits;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mA [1024];
  logic [31:0] mB [1024];
  bit          vA [1024];
  bit          vB [1024];

  always #5 PCLK = ~PCLK;

  apb4_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024),
                   .WAIT_STATES(0), .RO_BASE(512)) dutA (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(pselA),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PPROT(PPROT), .PREADY(readyA), .PRDATA(rdataA), .PSLVERR(errA));

  apb4_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024),
                   .WAIT_STATES(3), .RO_BASE(1024)) dutB (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(pselB),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PPROT(PPROT), .PREADY(readyB), .PRDATA(rdataB), .PSLVERR(errB));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_bus();
    pselA   = 1'b0;
    pselB   = 1'b0;
    PENABLE = 1'b0;
  endtask

  // One full APB transfer; expectation is modelled and queued at drive time
  task automatic xfer(input bit b, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input logic [2:0] prot, input string tag);
    exp_t        e;
    exp_t        o;
    int          idx;
    logic [31:0] cur;
    bit          v;
    int          waits;
    bit          done;
    idx = int'(addr >> 2);
    cur = '0;
    v   = 1'b0;
    if (idx < 1024) begin
      cur = b ? mB[idx] : mA[idx];
      v   = b ? vB[idx] : vA[idx];
    end
    e.tag      = tag;
    e.wr       = wr;
    e.err      = (idx >= 1024) || (addr[1:0] != 2'b00)
              || (wr && idx >= (b ? 1024 : 512))
              || (wr && !prot[0] && idx == 0);
    e.waits    = b ? 3 : 0;
    e.chk_data = !wr && (e.err || v);
    e.rdata    = e.err ? 32'h0 : cur;
    if (wr && !e.err) begin
      for (int l = 0; l < 4; l++)
        if (strb[l]) cur[l*8 +: 8] = wdata[l*8 +: 8];
      if (b) begin mB[idx] = cur; vB[idx] = v || (strb == 4'hF); end
      else   begin mA[idx] = cur; vA[idx] = v || (strb == 4'hF); end
    end
    sb.push_back(e);

    PADDR   = addr;
    PWRITE  = wr;
    PWDATA  = wdata;
    PSTRB   = strb;
    PPROT   = prot;
    pselA   = !b;
    pselB   = b;
    PENABLE = 1'b0;
    @(posedge PCLK) #1;
    PENABLE = 1'b1;
    waits = 0;
    done  = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge PCLK);
      if (b ? readyB : readyA) done = 1'b1;
      else begin
        check({tag, "_err_wait"}, {31'b0, b ? errB : errA}, 32'h0);
        waits++;
        @(posedge PCLK) #1;
      end
    end
    o = sb.pop_front();
    check({o.tag, "_timeout"}, {31'b0, done}, 32'h1);
    check({o.tag, "_waits"}, waits, o.waits);
    check({o.tag, "_slverr"}, {31'b0, b ? errB : errA}, {31'b0, o.err});
    if (o.chk_data) check({o.tag, "_rdata"}, b ? rdataB : rdataA, o.rdata);
    @(posedge PCLK) #1;
    idle_bus();
  endtask

  initial begin
    PRESETn = 1'b0;
    PADDR   = '0;
    PWRITE  = 1'b0;
    PWDATA  = '0;
    PSTRB   = '0;
    PPROT   = 3'b001;
    idle_bus();
    repeat (2) @(posedge PCLK);
    #1;
    check("rst_readyA", {31'b0, readyA}, 32'h0);
    check("rst_errA",   {31'b0, errA},   32'h0);
    check("rst_rdataA", rdataA, 32'h0);
    check("rst_rdataB", rdataB, 32'h0);
    PRESETn = 1'b1;

    // Basic write/read on both wait-state configurations
    xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b001, "A_wr10");
    xfer(0, 0, 32'h10, 32'h0,        4'hF, 3'b001, "A_rd10");
    xfer(1, 1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b001, "B_wr10");
    xfer(1, 0, 32'h10, 32'h0,        4'hF, 3'b001, "B_rd10");

    // Byte strobes
    xfer(0, 1, 32'h20, 32'h11223344, 4'hF, 3'b001, "A_wr20");
    xfer(0, 1, 32'h20, 32'hAABBCCDD, 4'h5, 3'b001, "A_wr20s");
    xfer(0, 0, 32'h20, 32'h0,        4'hF, 3'b001, "A_rd20");
    check("A_strb_value", rdataA, 32'h11BB33DD);
    xfer(0, 1, 32'h20, 32'h99999999, 4'h0, 3'b001, "A_wr20z");
    xfer(0, 0, 32'h20, 32'h0,        4'hF, 3'b001, "A_rd20z");

    // Error cases
    xfer(0, 0, 32'h1000, 32'h0,      4'hF, 3'b001, "A_rd_oob");
    xfer(0, 1, 32'h22, 32'h12345678, 4'hF, 3'b001, "A_wr_mis");
    xfer(0, 0, 32'h20, 32'h0,        4'hF, 3'b001, "A_rd20m");
    xfer(0, 1, 32'h800, 32'h5A5A5A5A, 4'hF, 3'b001, "A_wr_ro");
    xfer(0, 0, 32'h800, 32'h0,       4'hF, 3'b001, "A_rd_ro");
    check("A_ro_unchanged", {31'b0, rdataA === 32'h5A5A5A5A}, 32'h0);
    xfer(0, 1, 32'h0, 32'hCAFEF00D,  4'hF, 3'b001, "A_wr0p");
    xfer(0, 1, 32'h0, 32'h0BADBAD0,  4'hF, 3'b000, "A_wr0u");
    xfer(0, 0, 32'h0, 32'h0,         4'hF, 3'b000, "A_rd0");

    // Missing setup: PSEL and PENABLE together from IDLE
    PADDR = 32'h10; PWRITE = 1'b0; pselA = 1'b1; PENABLE = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge PCLK);
      check("A_nosetup_ready", {31'b0, readyA}, 32'h0);
    end
    @(posedge PCLK) #1;
    idle_bus();

    // Aborted write: PSEL drops during access
    xfer(0, 1, 32'h40, 32'h00000055, 4'hF, 3'b001, "A_wr40");
    PADDR = 32'h40; PWRITE = 1'b1; PWDATA = 32'h66; PSTRB = 4'hF;
    pselA = 1'b1; PENABLE = 1'b0;
    @(posedge PCLK) #1;
    pselA = 1'b0; PENABLE = 1'b1;
    @(negedge PCLK);
    check("A_abort_ready", {31'b0, readyA}, 32'h0);
    @(posedge PCLK) #1;
    idle_bus();
    xfer(0, 0, 32'h40, 32'h0, 4'hF, 3'b001, "A_rd40");

    // Reset during the second wait cycle of a write
    xfer(1, 1, 32'h30, 32'h01020304, 4'hF, 3'b001, "B_wr30");
    xfer(1, 0, 32'h30, 32'h0,        4'hF, 3'b001, "B_rd30");
    PADDR = 32'h30; PWRITE = 1'b1; PWDATA = 32'hFFFF0000; PSTRB = 4'hF;
    pselB = 1'b1; PENABLE = 1'b0;
    @(posedge PCLK) #1;
    PENABLE = 1'b1;
    @(posedge PCLK) #1;
    @(negedge PCLK);
    check("B_prerst_ready", {31'b0, readyB}, 32'h0);
    PRESETn = 1'b0;
    #1;
    check("B_rst_ready", {31'b0, readyB}, 32'h0);
    check("B_rst_err",   {31'b0, errB},   32'h0);
    check("B_rst_rdata", rdataB, 32'h0);
    idle_bus();
    @(posedge PCLK) #1;
    PRESETn = 1'b1;
    xfer(1, 0, 32'h30, 32'h0, 4'hF, 3'b001, "B_rd30r");
    xfer(0, 0, 32'h10, 32'h0, 4'hF, 3'b001, "A_rd10r");

    check("sb_empty", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/apb4_mem_slave.md
APB4_MEM_SLAVE -- requirements
Module: apb4_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning PADDR width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning PWDATA/PRDATA width; legal values 8, 16, 32, 64.
REQ-003 SHALL have parameter MEM_DEPTH, default 1024, meaning number of DATA_WIDTH words.
REQ-004 SHALL have parameter WAIT_STATES, default 0, meaning PREADY-low cycles inserted per access; legal range 0..15.
REQ-005 SHALL have parameter RO_BASE, default MEM_DEPTH, meaning first read-only word index; words RO_BASE..MEM_DEPTH-1 are read-only.
REQ-006 Ports, in order: PCLK in 1 clock; PRESETn in 1 reset; PADDR in ADDR_WIDTH byte address; PSEL in 1 select; PENABLE in 1 access phase; PWRITE in 1 1=write; PWDATA in DATA_WIDTH write data; PSTRB in DATA_WIDTH/8 byte-lane enables; PPROT in 3 protection; PREADY out 1 transfer complete; PRDATA out DATA_WIDTH read data; PSLVERR out 1 transfer error.
REQ-007 Reset SHALL be PRESETn, asynchronous, active-low; clock SHALL be PCLK.

Function
REQ-008 Word index SHALL be PADDR >> log2(DATA_WIDTH/8); byte offset SHALL be the PADDR bits below that.
REQ-009 FSM SHALL have states IDLE and ACCESS, plus a 4-bit wait counter CNT.
REQ-010 IDLE, PSEL=1 and PENABLE=0 (setup phase): SHALL go to ACCESS and load CNT=WAIT_STATES.
REQ-011 The same transition edge SHALL latch an error flag ERR and, for reads, SHALL load PRDATA with mem[index], or with 0 if ERR.
REQ-012 ERR SHALL be set when index >= MEM_DEPTH, when the byte offset is nonzero, or when the access is a write with index >= RO_BASE.
REQ-013 ERR SHALL also be set on a write with PPROT[0]=0 (unprivileged) to index 0.
REQ-014 ACCESS, PSEL=1, PENABLE=1, CNT!=0: PREADY SHALL be 0 and CNT SHALL decrement each cycle.
REQ-015 ACCESS, PSEL=1, PENABLE=1, CNT==0: PREADY SHALL be 1 for exactly that cycle and PSLVERR SHALL equal ERR; next state SHALL be IDLE.
REQ-016 In the REQ-015 cycle, a write with ERR=0 SHALL update only the byte lanes whose PSTRB bit is 1; PSTRB=0 SHALL be a legal no-op with no error.
REQ-017 A write with ERR=1 SHALL NOT modify memory.
REQ-018 PREADY and PSLVERR SHALL be 0 in IDLE; PSLVERR SHALL never be 1 while PREADY is 0.
REQ-019 PSEL=0 while in ACCESS (aborted transfer) SHALL return to IDLE next cycle, with no memory update and PREADY=0.
REQ-020 PSEL=1 with PENABLE=1 while in IDLE (missing setup) SHALL be ignored: no transfer, PREADY=0.
REQ-021 PRDATA SHALL hold its last value outside read transfers; writes SHALL NOT change PRDATA.
REQ-022 Back-to-back transfers SHALL be supported: a setup phase presented the cycle after PREADY=1 SHALL be accepted from IDLE.
REQ-023 PREADY, PSLVERR and the next-state logic SHALL depend only on state, CNT, ERR, PSEL and PENABLE, never directly on PADDR.

Reset
REQ-024 PRESETn=0 SHALL force IDLE, CNT=0, ERR=0, PRDATA=0, PREADY=0 and PSLVERR=0 immediately, independent of PCLK.
REQ-025 Reset asserted mid-transfer SHALL abort it with no memory write; memory contents SHALL NOT be reset.
REQ-026 After PRESETn rises, the first setup phase SHALL be accepted on the first PCLK edge.

Verification
REQ-027 WAIT_STATES=0: write 0xDEADBEEF to PADDR 0x10 with PSTRB=0xF, then read 0x10 -> each PREADY=1 in the first access cycle, PRDATA=0xDEADBEEF, PSLVERR=0.
REQ-028 WAIT_STATES=3: read PADDR 0x10 -> PREADY low for 3 access cycles, high on the 4th, PRDATA=0xDEADBEEF.
REQ-029 Write 0x11223344 to 0x20 with PSTRB=0xF, then 0xAABBCCDD with PSTRB=0x5, then read 0x20 -> 0x11BB33DD.
REQ-030 Read PADDR 0x1000 (MEM_DEPTH=1024, 32-bit data); write PADDR 0x22 -> both PSLVERR=1 with PREADY=1, PRDATA=0 on the read, memory unchanged.
REQ-031 RO_BASE=512: write PADDR 0x800 -> PSLVERR=1 and a subsequent read returns the old value; write PADDR 0 with PPROT=3'b000 -> PSLVERR=1.
REQ-032 Assert PRESETn=0 during a write's second wait cycle (WAIT_STATES=3) -> PREADY=0 and PRDATA=0 at once, target word unchanged on readback.
